// File: rtl/load_store_unit.sv
// Multi-cycle little-endian byte-array data memory stage with a fixed-latency access FSM.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject (not perform) accesses with addr[1:0] != 0.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        stall,
  output logic        misalign
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = 3;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              is_load_q;
  logic [31:0]       rdata_q;

  logic [7:0]        mem [Depth];

  logic              accept;
  logic              last_wait;
  logic              commit_store;
  logic              commit_load;
  logic              misaligned;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       load_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[31:ADDR_W];

  // The RESP cycle doubles as an accept slot so back-to-back requests lose no cycle.
  assign accept = ((state_q == StIdle) || (state_q == StResp)) && req_valid
                  && (mem_read || mem_write);

  assign last_wait = (state_q == StWait) && (cnt_q == CntW'(1));

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign commit_store = last_wait && !is_load_q && !misaligned;
  assign commit_load  = last_wait && is_load_q;

  // Byte addresses wrap naturally in ADDR_W-bit arithmetic.
  assign a0 = addr_q;
  assign a1 = addr_q + ADDR_W'(1);
  assign a2 = addr_q + ADDR_W'(2);
  assign a3 = addr_q + ADDR_W'(3);

  assign load_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntW'(LATENCY);
        end
      end
      StWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = CntW'(LATENCY);
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_load_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q    <= addr[ADDR_W-1:0];
        wdata_q   <= wdata;
        // A simultaneous read and write is a store.
        is_load_q <= mem_read && !mem_write;
      end
      if (commit_load) begin
        rdata_q <= misaligned ? 32'h0 : load_word;
      end
    end
  end

  // Storage is not reset; a reset edge cancels a pending commit.
  always_ff @(posedge CLK) begin
    if (RESET && commit_store) begin
      mem[a0] <= wdata_q[7:0];
      mem[a1] <= wdata_q[15:8];
      mem[a2] <= wdata_q[23:16];
      mem[a3] <= wdata_q[31:24];
    end
  end

  assign req_ready   = (state_q == StIdle) && RESET;
  assign stall       = (state_q != StIdle);
  assign done        = (state_q == StResp);
  assign rdata_valid = done && is_load_q;
  assign rdata       = rdata_q;
  assign misalign    = done && misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-array reference model.
module tb_load_store_unit;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;

  logic        CLK;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        stall;
  logic        misalign;

  int vectors;
  int miscompares;

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] ref_rdata;

  load_store_unit #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .stall       (stall),
    .misalign    (misalign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(a + 32'(i)) % DEPTH];
    return w;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) ref_mem[(a + 32'(i)) % DEPTH] = d[8*i +: 8];
  endtask

  function automatic logic is_mis(input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return (a & 32'h0) != 32'h0;
`endif
  endfunction

  // Apply the architectural effect of a completed access to the model.
  task automatic model_complete(input logic is_ld, input logic [31:0] a, input logic [31:0] d);
    if (is_mis(a)) begin
      if (is_ld) ref_rdata = 32'h0;
    end else if (is_ld) begin
      ref_rdata = ref_load(a);
    end else begin
      ref_store(a, d);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
    int   n;
    logic is_ld;
    @(negedge CLK);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = d;
    @(posedge CLK); #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom;
    if (!(rd || wr)) begin
      @(negedge CLK);
      check("noop_stall", stall, 0);
      check("noop_done", done, 0);
      return;
    end
    is_ld = rd && !wr;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      check("stall", stall, 1);
      check("ready_busy", req_ready, 0);
    end while (!done && n < 20);
    check("latency", n, LATENCY + 1);
    model_complete(is_ld, a, d);
    check("rdata_valid", rdata_valid, is_ld);
    check("misalign", misalign, is_mis(a));
    check("rdata", rdata, ref_rdata);
  endtask

  initial begin
    int n;
    logic [1:0] op;
    vectors = 0; miscompares = 0; ref_rdata = 32'h0;
    RESET = 1'b0; req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    // Reset held with a pending request: nothing may be accepted.
    repeat (2) begin
      @(negedge CLK);
      check("rst_ready", req_ready, 0);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_rdata", rdata, 0);
      check("rst_valid", rdata_valid, 0);
      check("rst_misalign", misalign, 0);
    end
    req_valid = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    check("post_rst_stall", stall, 0);
    check("post_rst_ready", req_ready, 1);

    // Give every byte a known value.
    for (int i = 0; i < int'(DEPTH) / 4; i++) access(1'b0, 1'b1, 32'(4 * i), $urandom);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);
    check("deadbeef", rdata, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h0, 32'h11223344);
    access(1'b1, 1'b0, 32'h0, 32'h0);
    check("byte_order", rdata, 32'h11223344);
    access(1'b1, 1'b0, 32'h3, 32'h0);

    access(1'b0, 1'b1, 32'h3FE, 32'hA1B2C3D4);
    access(1'b1, 1'b0, 32'h3FE, 32'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0);
`ifndef LSU_ALIGN_CHECK_EN
    check("wrap_low", rdata[15:0], 16'hA1B2);
`endif

    // Read+write together behaves as a store.
    access(1'b1, 1'b1, 32'h40, 32'h5A5A1234);
    access(1'b1, 1'b0, 32'h40, 32'h0);

    // Held request with wandering address; back-to-back accept in the done cycle.
    @(negedge CLK);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10;
    @(posedge CLK); #1;
    for (int k = 1; k <= int'(LATENCY) + 1; k++) begin
      @(negedge CLK);
      check("hold_stall", stall, 1);
      check("hold_ready", req_ready, 0);
      check("hold_done", done, k == int'(LATENCY) + 1);
      addr = $urandom;
    end
    model_complete(1'b1, 32'h10, 32'h0);
    check("hold_rdata", rdata, ref_rdata);
    check("hold_valid", rdata_valid, 1);
    addr = 32'h0;
    @(posedge CLK); #1;
    req_valid = 1'b0; addr = $urandom;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      check("b2b_stall", stall, 1);
    end while (!done && n < 20);
    check("b2b_latency", n, LATENCY + 1);
    model_complete(1'b1, 32'h0, 32'h0);
    check("b2b_rdata", rdata, ref_rdata);

    // Reset during WAIT of a store drops the store.
    @(negedge CLK);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    check("mid_stall", stall, 1);
    RESET = 1'b0;
    @(negedge CLK);
    ref_rdata = 32'h0;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdata", rdata, ref_rdata);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_no_done", done, 0);
    access(1'b1, 1'b0, 32'h20, 32'h0);
    access(1'b1, 1'b0, 32'h21, 32'h0);

    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      access(op[0], op[1], $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
